// File: rtl/fp_alu_issuer.sv
// Command-side initiator for the single-precision FP ALU: queues requests,
// issues them one at a time, and returns tagged responses with a watchdog.
module fp_alu_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_tag,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  input  logic [31:0] alu_result,
  input  logic        alu_done,
  input  logic        alu_overflow,
  input  logic        alu_underflow,
  input  logic        alu_invalid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  rsp_tag,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [3:0]  tag;
    logic [1:0]  op;
    logic [31:0] b;
    logic [31:0] a;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          head;
  logic          push;
  logic          empty;
  logic          full_d;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [3:0]    tag_q, tag_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic [31:0]   alu_a_q, alu_a_d;
  logic [31:0]   alu_b_q, alu_b_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic          alu_start_q, alu_start_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_result_q, rsp_result_d;
  logic [3:0]    rsp_flags_q, rsp_flags_d;
  logic [3:0]    rsp_tag_q, rsp_tag_d;
  logic          busy_q, busy_d;

  assign push  = cmd_valid && cmd_ready_q;
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= cmd_t'({cmd_tag, cmd_op, cmd_b, cmd_a});
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    wd_d         = wd_q;
    tag_d        = tag_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_start_d  = alu_start_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_tag_d    = rsp_tag_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          rd_ptr_d    = rd_ptr_q + PW'(1);
          alu_a_d     = head.a;
          alu_b_d     = head.b;
          alu_op_d    = head.op;
          tag_d       = head.tag;
          alu_start_d = 1'b1;
          wd_d        = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        alu_start_d = 1'b0;
        // A done arriving in the final watchdog cycle still reports the real result.
        if (alu_done) begin
          rsp_result_d = alu_result;
          rsp_flags_d  = {1'b0, alu_invalid, alu_underflow, alu_overflow};
          rsp_tag_d    = tag_q;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else if (wd_q == WW'(TIMEOUT)) begin
          rsp_result_d = QNAN;
          rsp_flags_d  = 4'b1000;
          rsp_tag_d    = tag_q;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    full_d      = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    cmd_ready_d = !full_d;
    busy_d      = (wr_ptr_d != rd_ptr_d) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wd_q         <= '0;
      tag_q        <= '0;
      cmd_ready_q  <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_tag_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wd_q         <= wd_d;
      tag_q        <= tag_d;
      cmd_ready_q  <= cmd_ready_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_start_q  <= alu_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_tag_q    <= rsp_tag_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_start  = alu_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_tag    = rsp_tag_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fp_alu_issuer.sv
// Directed bench for fp_alu_issuer with a latency-accurate stub of the FP ALU.
module tb_fp_alu_issuer;

  localparam int TO = 63;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_tag;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic        alu_start;
  logic [31:0] alu_result;
  logic        alu_done, alu_overflow, alu_underflow, alu_invalid;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags, rsp_tag;
  logic        busy;

  fp_alu_issuer #(.DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_result(alu_result), .alu_done(alu_done),
    .alu_overflow(alu_overflow), .alu_underflow(alu_underflow), .alu_invalid(alu_invalid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int push_edge = 0;
  int start_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (alu_start) start_cnt = start_cnt + 1;

  // ALU stub: done after 4/29/2 negedges for plain ops, DIV, NaN/div-by-zero shortcut.
  bit stub_never = 0;
  int stub_lat_ovr = 0;
  logic force_done = 1'b0;
  int stub_cnt = 0;

  function automatic void alu_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] op, output logic [31:0] res,
                                    output logic [2:0] fl, output int lat);
    bit a_nan, b_nan;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    fl = 3'b000;
    res = 32'h0;
    if (a_nan || b_nan || (op == 2'b11 && b[30:0] == 31'd0)) begin
      res = 32'h7FC0_0000; fl = 3'b100; lat = 2;
    end else begin
      lat = (op == 2'b11) ? 29 : 4;
      case ({op, a, b})
        {2'b00, 32'h3F80_0000, 32'h4000_0000}: res = 32'h4040_0000;
        {2'b00, 32'h4000_0000, 32'h4000_0000}: res = 32'h4080_0000;
        {2'b01, 32'h4040_0000, 32'h3F80_0000}: res = 32'h4000_0000;
        {2'b10, 32'h3F80_0000, 32'h4000_0000}: res = 32'h4000_0000;
        {2'b11, 32'h40C0_0000, 32'h4000_0000}: res = 32'h4040_0000;
        {2'b10, 32'h7F00_0000, 32'h7F00_0000}: begin res = 32'h7F80_0000; fl = 3'b001; end
        {2'b10, 32'h0080_0000, 32'h0080_0000}: begin res = 32'h0000_0000; fl = 3'b010; end
        default: res = 32'hDEAD_BEEF;
      endcase
    end
  endfunction

  always @(negedge clk) begin
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    alu_done = force_done;
    if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) alu_done = 1'b1;
    end
    if (alu_start && !stub_never) begin
      alu_model(alu_a, alu_b, alu_op, r, f, l);
      alu_result = r;
      {alu_invalid, alu_underflow, alu_overflow} = f;
      stub_cnt = (stub_lat_ovr != 0) ? stub_lat_ovr : l;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [3:0] tag);
    int g;
    g = 0;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    while (!cmd_ready && g < 300) begin
      @(negedge clk);
      g = g + 1;
    end
    if (g >= 300) check("push_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    push_edge = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    int g;
    g = 0;
    ok = 0;
    while (!ok && g < 300) begin
      @(posedge clk);
      #1;
      if (rsp_valid) ok = 1;
      g = g + 1;
    end
    if (!ok) check("rsp_wait_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  vec_t vt [8];
  vec_t fill [5];

  initial begin : main
    bit ok;
    int s0;
    bit bad;

    vt[0] = '{32'h3F80_0000, 32'h4000_0000, 2'b00, 4'h5, 32'h4040_0000, 4'b0000, 6};
    vt[1] = '{32'h3F80_0000, 32'h4000_0000, 2'b10, 4'h3, 32'h4000_0000, 4'b0000, 6};
    vt[2] = '{32'h40C0_0000, 32'h4000_0000, 2'b11, 4'hA, 32'h4040_0000, 4'b0000, 31};
    vt[3] = '{32'h4040_0000, 32'h3F80_0000, 2'b01, 4'hC, 32'h4000_0000, 4'b0000, 6};
    vt[4] = '{32'h7FC0_0000, 32'h3F80_0000, 2'b00, 4'hF, 32'h7FC0_0000, 4'b0100, 4};
    vt[5] = '{32'h3F80_0000, 32'h0000_0000, 2'b11, 4'h0, 32'h7FC0_0000, 4'b0100, 4};
    vt[6] = '{32'h7F00_0000, 32'h7F00_0000, 2'b10, 4'h6, 32'h7F80_0000, 4'b0001, 6};
    vt[7] = '{32'h0080_0000, 32'h0080_0000, 2'b10, 4'h9, 32'h0000_0000, 4'b0010, 6};

    fill[0] = '{32'h3F80_0000, 32'h4000_0000, 2'b10, 4'h0, 32'h4000_0000, 4'b0000, 0};
    fill[1] = '{32'h40C0_0000, 32'h4000_0000, 2'b11, 4'h1, 32'h4040_0000, 4'b0000, 0};
    fill[2] = '{32'h4040_0000, 32'h3F80_0000, 2'b01, 4'h2, 32'h4000_0000, 4'b0000, 0};
    fill[3] = '{32'h7FC0_0000, 32'h3F80_0000, 2'b00, 4'h3, 32'h7FC0_0000, 4'b0100, 0};
    fill[4] = '{32'h3F80_0000, 32'h0000_0000, 2'b11, 4'h4, 32'h7FC0_0000, 4'b0100, 0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    rsp_ready = 1'b1; alu_done = 1'b0; alu_result = '0;
    alu_overflow = 1'b0; alu_underflow = 1'b0; alu_invalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_alu_a", alu_a, 32'd0);
    check("reset_alu_b", alu_b, 32'd0);
    check("reset_alu_op_start", {30'd0, alu_op} | 32'({alu_start, 2'b00}), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    check("reset_rsp_flags_tag", {24'd0, rsp_flags, rsp_tag}, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single commands with an always-ready consumer.
    for (int i = 0; i < 8; i++) begin
      s0 = start_cnt;
      push(vt[i].a, vt[i].b, vt[i].op, vt[i].tag);
      check($sformatf("v%0d_busy_after_push", i), 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_start_hi", i), 32'(alu_start), 32'd1);
      check($sformatf("v%0d_alu_a", i), alu_a, vt[i].a);
      check($sformatf("v%0d_alu_b_op", i), alu_b ^ 32'(alu_op), vt[i].b ^ 32'(vt[i].op));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_start_lo", i), 32'(alu_start), 32'd0);
      wait_rsp(ok);
      if (ok) begin
        check($sformatf("v%0d_latency", i), 32'(cyc - push_edge), 32'(vt[i].lat));
        check($sformatf("v%0d_result", i), rsp_result, vt[i].res);
        check($sformatf("v%0d_flags", i), 32'(rsp_flags), 32'(vt[i].flags));
        check($sformatf("v%0d_tag", i), 32'(rsp_tag), 32'(vt[i].tag));
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d_idle_after", i), {30'd0, rsp_valid, busy}, 32'd0);
      check($sformatf("v%0d_alu_a_held", i), alu_a, vt[i].a);
      check($sformatf("v%0d_one_start", i), 32'(start_cnt - s0), 32'd1);
    end

    // Fill the FIFO behind an in-flight command; responses return in order.
    for (int i = 0; i < 5; i++) begin
      push(fill[i].a, fill[i].b, fill[i].op, fill[i].tag);
    end
    check("fill_cmd_ready_low", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      wait_rsp(ok);
      if (ok) begin
        check($sformatf("fill%0d_tag", i), 32'(rsp_tag), 32'(fill[i].tag));
        check($sformatf("fill%0d_result", i), rsp_result, fill[i].res);
        check($sformatf("fill%0d_flags", i), 32'(rsp_flags), 32'(fill[i].flags));
      end
    end
    @(posedge clk);
    #1;
    check("fill_drained", {30'd0, cmd_ready, busy}, 32'd2);

    // Response backpressure.
    rsp_ready = 1'b0;
    push(32'h3F80_0000, 32'h4000_0000, 2'b00, 4'h7);
    push(32'h4000_0000, 32'h4000_0000, 2'b00, 4'h8);
    wait_rsp(ok);
    s0 = start_cnt;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!rsp_valid || rsp_result !== 32'h4040_0000 || rsp_tag !== 4'h7 ||
          rsp_flags !== 4'h0 || alu_start || !busy || !cmd_ready) bad = 1;
    end
    check("bp_outputs_held", 32'(bad), 32'd0);
    check("bp_no_new_start", 32'(start_cnt - s0), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid_low", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_next_pop_start", 32'(alu_start), 32'd1);
    check("bp_next_pop_a", alu_a, 32'h4000_0000);
    wait_rsp(ok);
    if (ok) begin
      check("bp_second_tag", 32'(rsp_tag), 32'h8);
      check("bp_second_result", rsp_result, 32'h4080_0000);
    end

    // Watchdog timeout, then a late done that must be ignored.
    stub_never = 1;
    push(32'h3F80_0000, 32'h4000_0000, 2'b10, 4'h9);
    wait_rsp(ok);
    if (ok) begin
      check("to_latency", 32'(cyc - push_edge), 32'(TO + 2));
      check("to_result", rsp_result, 32'h7FC0_0000);
      check("to_flags", 32'(rsp_flags), 32'h8);
      check("to_tag", 32'(rsp_tag), 32'h9);
    end
    repeat (5) @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy) bad = 1;
    end
    check("to_late_done_ignored", 32'(bad), 32'd0);
    stub_never = 0;

    // Done arrives in the final watchdog cycle: the real result wins.
    stub_lat_ovr = TO;
    push(32'h3F80_0000, 32'h4000_0000, 2'b00, 4'h2);
    wait_rsp(ok);
    if (ok) begin
      check("coin_latency", 32'(cyc - push_edge), 32'(TO + 2));
      check("coin_result", rsp_result, 32'h4040_0000);
      check("coin_flags", 32'(rsp_flags), 32'h0);
    end
    stub_lat_ovr = 0;
    repeat (2) @(posedge clk);

    // Reset during a DIV with two commands queued.
    push(32'h40C0_0000, 32'h4000_0000, 2'b11, 4'h1);
    push(32'h3F80_0000, 32'h4000_0000, 2'b00, 4'h2);
    push(32'h3F80_0000, 32'h4000_0000, 2'b00, 4'h3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_alu_a", alu_a, 32'd0);
    check("rst_mid_alu_b", alu_b, 32'd0);
    check("rst_mid_ctrl", {27'd0, alu_start, rsp_valid, busy, cmd_ready, 1'b0}, 32'h2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = start_cnt;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy || !cmd_ready) bad = 1;
    end
    check("rst_no_response", 32'(bad), 32'd0);
    check("rst_no_start", 32'(start_cnt - s0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
